// File: rtl/t2mi_pkg.sv
// Shared definitions for the T2-MI receive path: framing sizes, packet type codes,
// parser state encodings, output bundle and the MSB-first CRC-32 byte step.
`timescale 1ns/1ps
package t2mi_pkg;

  localparam int HDR_LEN = 6;
  localparam int CRC_LEN = 4;
  localparam int IDX_W   = 13;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  typedef enum logic [7:0] {
    PKT_BB_FRAME   = 8'h00,
    PKT_L1_CURRENT = 8'h10,
    PKT_TIMESTAMP  = 8'h20
  } pkt_type_e;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CRC     = 3'd3
  } state_e;

  // Everything the parser presents to the outside world, registered as one bundle.
  typedef struct packed {
    logic [7:0]       payload;
    logic             payload_ena;
    logic [IDX_W-1:0] payload_idx;
    logic [7:0]       pkt_type;
    logic [7:0]       packet_count;
    logic [3:0]       superframe_idx;
    logic [2:0]       stream_id;
    logic [15:0]      payload_len;
    logic             hdr_valid;
    logic             pkt_done;
    logic             crc_ok;
    logic             cc_err;
    logic             len_err;
    logic             abort;
  } out_t;

  // Header bytes held until the last header byte arrives.
  typedef struct packed {
    logic [7:0] pkt_type;
    logic [7:0] packet_count;
    logic [3:0] superframe_idx;
    logic [2:0] stream_id;
    logic [7:0] len_hi;
  } hdr_t;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                              input logic [7:0]  data);
    logic [31:0] crc;
    logic        fb;
    crc = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb  = crc[31] ^ data[i];
      crc = {crc[30:0], 1'b0};
      if (fb) crc = crc ^ CRC_POLY;
    end
    return crc;
  endfunction

endpackage

// File: rtl/t2mi_crc32_check.sv
// Byte-wide MPEG-2 CRC-32 (no reflection, no final XOR) with synchronous init.
// crc_next is the value the register takes at the coming edge, including this byte.
`timescale 1ns/1ps
module t2mi_crc32_check
  import t2mi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        ena,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  logic [31:0] crc_q, crc_d;

  // NOTE: combinational logic uses blocking '=' with every output given a default
  // first, so no latch is inferred; the flop below takes its value with '<='.
  always_comb begin
    crc_d = crc_q;
    if (ena) crc_d = crc32_byte(init ? CRC_INIT : crc_q, data);
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= CRC_INIT;
    else     crc_q <= crc_d;
  end

  assign crc_next = crc_d;

endmodule

// File: rtl/t2mi_packet_parser.sv
// T2-MI packet parser: header decode, indexed payload forwarding, CRC-32 and
// packet_count continuity checks. Advances only on bytes with ENA_IN=1.
`timescale 1ns/1ps
module t2mi_packet_parser
  import t2mi_pkg::*;
#(
  parameter int MAX_PAYLOAD_BYTES = 6733
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       DATA_IN,
  input  logic             ENA_IN,
  input  logic             SOP_IN,
  output logic [7:0]       PAYLOAD_OUT,
  output logic             PAYLOAD_ENA,
  output logic [IDX_W-1:0] PAYLOAD_IDX,
  output logic [7:0]       PKT_TYPE,
  output logic [7:0]       PACKET_COUNT,
  output logic [3:0]       SUPERFRAME_IDX,
  output logic [2:0]       STREAM_ID,
  output logic [15:0]      PAYLOAD_LEN,
  output logic             HDR_VALID,
  output logic             PKT_DONE,
  output logic             CRC_OK,
  output logic             CC_ERR,
  output logic             LEN_ERR,
  output logic             ABORT,
  output logic [2:0]       state_mon
);

  localparam logic [IDX_W-1:0] MAX_BYTES = IDX_W'(MAX_PAYLOAD_BYTES);
  localparam logic [2:0]       HDR_LAST  = 3'(HDR_LEN - 1);
  localparam logic [1:0]       CRC_LAST  = 2'(CRC_LEN - 1);

  state_e           state_q, state_d;
  logic [2:0]       hdr_cnt_q, hdr_cnt_d;
  logic [IDX_W-1:0] pay_cnt_q, pay_cnt_d;
  logic [IDX_W-1:0] pay_len_q, pay_len_d;
  logic [1:0]       crc_cnt_q, crc_cnt_d;
  logic             first_q, first_d;
  logic [7:0]       prev_cc_q, prev_cc_d;
  logic             cc_bad_q, cc_bad_d;
  hdr_t             hdr_q, hdr_d;
  out_t             out_q, out_d;

  logic             crc_init, crc_ena;
  logic [31:0]      crc_next;
  logic [16:0]      len_round;
  logic [IDX_W-1:0] pay_bytes;

  t2mi_crc32_check u_crc (
    .clk      (CLK),
    .rst      (RST),
    .init     (crc_init),
    .ena      (crc_ena),
    .data     (DATA_IN),
    .crc_next (crc_next)
  );

  // Bit length rounded up to whole bytes; 17 bits so 16'hFFFF+7 cannot wrap early.
  assign len_round = {1'b0, hdr_q.len_hi, DATA_IN} + 17'd7;
  assign pay_bytes = IDX_W'(len_round >> 3);

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    pay_cnt_d = pay_cnt_q;
    pay_len_d = pay_len_q;
    crc_cnt_d = crc_cnt_q;
    first_d   = first_q;
    prev_cc_d = prev_cc_q;
    cc_bad_d  = cc_bad_q;
    hdr_d     = hdr_q;
    out_d     = out_q;
    crc_init  = 1'b0;
    crc_ena   = ENA_IN;

    out_d.payload_ena = 1'b0;
    out_d.hdr_valid   = 1'b0;
    out_d.pkt_done    = 1'b0;
    out_d.crc_ok      = 1'b0;
    out_d.cc_err      = 1'b0;
    out_d.len_err     = 1'b0;
    out_d.abort       = 1'b0;

    if (ENA_IN) begin
      if (SOP_IN) begin
        // A start inside a packet abandons it; the byte still opens a new packet.
        out_d.abort    = (state_q != ST_HUNT);
        crc_init       = 1'b1;
        hdr_d.pkt_type = DATA_IN;
        hdr_cnt_d      = 3'd1;
        crc_cnt_d      = 2'd0;
        state_d        = ST_HEADER;
      end else begin
        unique case (state_q)
          ST_HUNT: ;

          ST_HEADER: begin
            hdr_cnt_d = hdr_cnt_q + 3'd1;
            if (hdr_cnt_q == 3'd1) begin
              hdr_d.packet_count = DATA_IN;
              cc_bad_d  = !first_q && (DATA_IN != prev_cc_q + 8'd1);
              first_d   = 1'b0;
              prev_cc_d = DATA_IN;
            end else if (hdr_cnt_q == 3'd2) begin
              hdr_d.superframe_idx = DATA_IN[7:4];
            end else if (hdr_cnt_q == 3'd3) begin
              hdr_d.stream_id = DATA_IN[2:0];
            end else if (hdr_cnt_q == 3'd4) begin
              hdr_d.len_hi = DATA_IN;
            end else if (hdr_cnt_q == HDR_LAST) begin
              out_d.pkt_type       = hdr_q.pkt_type;
              out_d.packet_count   = hdr_q.packet_count;
              out_d.superframe_idx = hdr_q.superframe_idx;
              out_d.stream_id      = hdr_q.stream_id;
              out_d.payload_len    = {hdr_q.len_hi, DATA_IN};
              out_d.hdr_valid      = 1'b1;
              out_d.cc_err         = cc_bad_q;
              pay_cnt_d            = '0;
              pay_len_d            = pay_bytes;
              crc_cnt_d            = 2'd0;
              if (pay_bytes > MAX_BYTES) begin
                out_d.len_err = 1'b1;
                state_d       = ST_HUNT;
              end else if (pay_bytes == '0) begin
                state_d = ST_CRC;
              end else begin
                state_d = ST_PAYLOAD;
              end
            end
          end

          ST_PAYLOAD: begin
            out_d.payload     = DATA_IN;
            out_d.payload_ena = 1'b1;
            out_d.payload_idx = pay_cnt_q;
            pay_cnt_d         = pay_cnt_q + 1'b1;
            if (pay_cnt_q == pay_len_q - 1'b1) begin
              crc_cnt_d = 2'd0;
              state_d   = ST_CRC;
            end
          end

          ST_CRC: begin
            crc_cnt_d = crc_cnt_q + 2'd1;
            if (crc_cnt_q == CRC_LAST) begin
              // Residual over header, payload and transmitted CRC is zero when intact.
              out_d.pkt_done = 1'b1;
              out_d.crc_ok   = (crc_next == 32'h0);
              state_d        = ST_HUNT;
            end
          end

          default: state_d = ST_HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_HUNT;
      hdr_cnt_q <= '0;
      pay_cnt_q <= '0;
      pay_len_q <= '0;
      crc_cnt_q <= '0;
      first_q   <= 1'b1;
      prev_cc_q <= '0;
      cc_bad_q  <= 1'b0;
      hdr_q     <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      pay_len_q <= pay_len_d;
      crc_cnt_q <= crc_cnt_d;
      first_q   <= first_d;
      prev_cc_q <= prev_cc_d;
      cc_bad_q  <= cc_bad_d;
      hdr_q     <= hdr_d;
      out_q     <= out_d;
    end
  end

  assign PAYLOAD_OUT    = out_q.payload;
  assign PAYLOAD_ENA    = out_q.payload_ena;
  assign PAYLOAD_IDX    = out_q.payload_idx;
  assign PKT_TYPE       = out_q.pkt_type;
  assign PACKET_COUNT   = out_q.packet_count;
  assign SUPERFRAME_IDX = out_q.superframe_idx;
  assign STREAM_ID      = out_q.stream_id;
  assign PAYLOAD_LEN    = out_q.payload_len;
  assign HDR_VALID      = out_q.hdr_valid;
  assign PKT_DONE       = out_q.pkt_done;
  assign CRC_OK         = out_q.crc_ok;
  assign CC_ERR         = out_q.cc_err;
  assign LEN_ERR        = out_q.len_err;
  assign ABORT          = out_q.abort;
  assign state_mon      = state_q;

endmodule

// File: tb/tb_t2mi_packet_parser.sv
// Directed bench for t2mi_packet_parser: builds packets with their own CRC and
// checks pulses, header fields and forwarded payload observed on the falling edge.
`timescale 1ns/1ps
module tb_t2mi_packet_parser;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  DATA_IN = 8'h00;
  logic        ENA_IN = 1'b0;
  logic        SOP_IN = 1'b0;
  logic [7:0]  PAYLOAD_OUT;
  logic        PAYLOAD_ENA;
  logic [12:0] PAYLOAD_IDX;
  logic [7:0]  PKT_TYPE;
  logic [7:0]  PACKET_COUNT;
  logic [3:0]  SUPERFRAME_IDX;
  logic [2:0]  STREAM_ID;
  logic [15:0] PAYLOAD_LEN;
  logic        HDR_VALID, PKT_DONE, CRC_OK, CC_ERR, LEN_ERR, ABORT;
  logic [2:0]  state_mon;

  t2mi_packet_parser dut (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .ENA_IN(ENA_IN), .SOP_IN(SOP_IN),
    .PAYLOAD_OUT(PAYLOAD_OUT), .PAYLOAD_ENA(PAYLOAD_ENA), .PAYLOAD_IDX(PAYLOAD_IDX),
    .PKT_TYPE(PKT_TYPE), .PACKET_COUNT(PACKET_COUNT), .SUPERFRAME_IDX(SUPERFRAME_IDX),
    .STREAM_ID(STREAM_ID), .PAYLOAD_LEN(PAYLOAD_LEN), .HDR_VALID(HDR_VALID),
    .PKT_DONE(PKT_DONE), .CRC_OK(CRC_OK), .CC_ERR(CC_ERR), .LEN_ERR(LEN_ERR),
    .ABORT(ABORT), .state_mon(state_mon)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Event monitor on the falling edge, away from the active edge.
  int          n_hdr = 0, n_pay = 0, n_done = 0, n_ok = 0, n_cc = 0, n_len = 0, n_abort = 0;
  logic [7:0]  pay_data[$];
  logic [12:0] pay_idx[$];
  logic [7:0]  m_type = 8'h00, m_count = 8'h00;
  logic [3:0]  m_sf = 4'h0;
  logic [2:0]  m_sid = 3'h0;
  logic [15:0] m_len = 16'h0;

  always @(negedge CLK) begin
    if (HDR_VALID === 1'b1) begin
      n_hdr++;
      m_type = PKT_TYPE; m_count = PACKET_COUNT; m_sf = SUPERFRAME_IDX;
      m_sid = STREAM_ID; m_len = PAYLOAD_LEN;
    end
    if (PAYLOAD_ENA === 1'b1) begin
      n_pay++;
      pay_data.push_back(PAYLOAD_OUT);
      pay_idx.push_back(PAYLOAD_IDX);
    end
    if (PKT_DONE === 1'b1) begin
      n_done++;
      if (CRC_OK === 1'b1) n_ok++;
    end
    if (CC_ERR === 1'b1)  n_cc++;
    if (LEN_ERR === 1'b1) n_len++;
    if (ABORT === 1'b1)   n_abort++;
  end

  int b_hdr, b_pay, b_done, b_ok, b_cc, b_len, b_abort;

  task automatic snap();
    b_hdr = n_hdr; b_pay = n_pay; b_done = n_done; b_ok = n_ok;
    b_cc = n_cc; b_len = n_len; b_abort = n_abort;
  endtask

  task automatic settle();
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic check_counts(input string tag, input int hdr, input int pay, input int done,
                              input int ok, input int cc, input int len, input int abrt);
    check({tag, ".hdr"},   n_hdr - b_hdr,     hdr);
    check({tag, ".pay"},   n_pay - b_pay,     pay);
    check({tag, ".done"},  n_done - b_done,   done);
    check({tag, ".crcok"}, n_ok - b_ok,       ok);
    check({tag, ".cc"},    n_cc - b_cc,       cc);
    check({tag, ".len"},   n_len - b_len,     len);
    check({tag, ".abort"}, n_abort - b_abort, abrt);
  endtask

  // Packet under construction: 6 header bytes, payload, 4 CRC bytes MSB first.
  logic [7:0]  pkt[$];
  logic [7:0]  ref_data[$];
  logic [12:0] ref_idx[$];
  int          gap_mode = 0;

  task automatic build(input logic [7:0] typ, input logic [7:0] cnt, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [15:0] len, input int npay,
                       input logic [7:0] seed);
    logic [31:0] c;
    pkt.delete();
    pkt.push_back(typ); pkt.push_back(cnt); pkt.push_back(b2); pkt.push_back(b3);
    pkt.push_back(len[15:8]); pkt.push_back(len[7:0]);
    for (int i = 0; i < npay; i++) pkt.push_back(8'(seed + 8'(i * 37)));
    c = 32'hFFFFFFFF;
    foreach (pkt[i]) begin
      c = c ^ {pkt[i], 24'h0};
      for (int b = 0; b < 8; b++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    pkt.push_back(c[31:24]); pkt.push_back(c[23:16]);
    pkt.push_back(c[15:8]);  pkt.push_back(c[7:0]);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic sop);
    if (gap_mode != 0) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge CLK);
        ENA_IN = 1'b0; DATA_IN = 8'($urandom); SOP_IN = 1'($urandom);
      end
    end
    @(negedge CLK);
    DATA_IN = b; SOP_IN = sop; ENA_IN = 1'b1;
    @(posedge CLK);
    #1;
    ENA_IN = 1'b0; SOP_IN = 1'b0;
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(pkt[i], i == 0);
  endtask

  task automatic check_payload(input string tag, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      if (base + i < pay_data.size()) begin
        check({tag, ".data"}, pay_data[base + i], pkt[6 + i]);
        check({tag, ".idx"},  pay_idx[base + i],  i);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge CLK);
    #1;
    check("rst.state", state_mon, 3'd0);
    check("rst.pay_ena", PAYLOAD_ENA, 1'b0);
    check("rst.hdr_valid", HDR_VALID, 1'b0);
    check("rst.pkt_done", PKT_DONE, 1'b0);
    check("rst.crc_ok", CRC_OK, 1'b0);
    check("rst.pulses", {CC_ERR, LEN_ERR, ABORT}, 3'b000);
    check("rst.fields", {PKT_TYPE, PACKET_COUNT, PAYLOAD_LEN}, 32'h0);
    check("rst.misc", {PAYLOAD_OUT, PAYLOAD_IDX, SUPERFRAME_IDX, STREAM_ID}, 28'h0);
    RST = 1'b0;
    settle();

    // Timestamp packet, 88 bits -> 11 payload bytes.
    snap();
    build(8'h20, 8'h05, 8'h00, 8'h00, 16'h0058, 11, 8'h11);
    send_range(0, pkt.size() - 1);
    settle();
    check_counts("ts", 1, 11, 1, 1, 0, 0, 0);
    check("ts.type", m_type, 8'h20);
    check("ts.len", m_len, 16'h0058);
    check("ts.count", m_count, 8'h05);
    check_payload("ts", b_pay, 11);
    for (int i = 0; i < 11; i++) begin
      ref_data.push_back(pay_data[b_pay + i]);
      ref_idx.push_back(pay_idx[b_pay + i]);
    end
    check("ts.state", state_mon, 3'd0);

    // Corrupted payload byte 3: payload still forwarded, CRC fails.
    snap();
    build(8'h20, 8'h06, 8'h00, 8'h00, 16'h0058, 11, 8'h11);
    pkt[9] = pkt[9] ^ 8'h01;
    send_range(0, pkt.size() - 1);
    settle();
    check_counts("bad", 1, 11, 1, 0, 0, 0, 0);
    check_payload("bad", b_pay, 11);

    // Continuity: 06 -> FF breaks, FF -> 00 wraps cleanly, 00 -> 05 and 05 -> 07 break.
    snap();
    build(8'h10, 8'hFF, 8'h00, 8'h00, 16'h0008, 1, 8'h40);
    send_range(0, pkt.size() - 1);
    settle();
    check_counts("ccff", 1, 1, 1, 1, 1, 0, 0);
    snap();
    build(8'h10, 8'h00, 8'h00, 8'h00, 16'h0008, 1, 8'h41);
    send_range(0, pkt.size() - 1);
    settle();
    check_counts("cc00", 1, 1, 1, 1, 0, 0, 0);
    check("cc00.count", m_count, 8'h00);
    snap();
    build(8'h10, 8'h05, 8'h00, 8'h00, 16'h0008, 1, 8'h42);
    send_range(0, pkt.size() - 1);
    settle();
    check_counts("cc05", 1, 1, 1, 1, 1, 0, 0);
    snap();
    build(8'h10, 8'h07, 8'h00, 8'h00, 16'h0008, 1, 8'h43);
    send_range(0, pkt.size() - 1);
    settle();
    check_counts("cc07", 1, 1, 1, 1, 1, 0, 0);

    // 9 bits -> 2 payload bytes; also decode of the superframe/stream fields.
    snap();
    build(8'h00, 8'h08, 8'hA7, 8'hFD, 16'h0009, 2, 8'h90);
    send_range(0, pkt.size() - 1);
    settle();
    check_counts("len9", 1, 2, 1, 1, 0, 0, 0);
    check_payload("len9", b_pay, 2);
    check("len9.sf", m_sf, 4'hA);
    check("len9.sid", m_sid, 3'h5);

    // Zero-length payload goes straight to the CRC bytes.
    snap();
    build(8'h00, 8'h09, 8'h00, 8'h00, 16'h0000, 0, 8'h00);
    send_range(0, pkt.size() - 1);
    settle();
    check_counts("len0", 1, 0, 1, 1, 0, 0, 0);

    // 16'hFFF8 -> 8191 bytes: length error, trailing bytes ignored.
    snap();
    build(8'h00, 8'h0A, 8'h00, 8'h00, 16'hFFF8, 0, 8'h00);
    send_range(0, 5);
    for (int i = 0; i < 20; i++) send_byte(8'(8'h47 + i), 1'b0);
    settle();
    check_counts("lenerr", 1, 0, 0, 0, 0, 1, 0);
    check("lenerr.len", m_len, 16'hFFF8);
    check("lenerr.state", state_mon, 3'd0);

    // SOP at payload index 4 aborts; the new packet completes cleanly.
    snap();
    build(8'h20, 8'h0B, 8'h00, 8'h00, 16'h0058, 11, 8'h22);
    send_range(0, 9);
    build(8'h20, 8'h0C, 8'h00, 8'h00, 16'h0058, 11, 8'h33);
    send_range(0, pkt.size() - 1);
    settle();
    check_counts("abort", 2, 15, 1, 1, 0, 0, 1);
    check_payload("abort.new", b_pay + 4, 11);

    // First case again with stalls and masked SOP: same payload sequence.
    snap();
    gap_mode = 1;
    build(8'h20, 8'h0D, 8'h00, 8'h00, 16'h0058, 11, 8'h11);
    send_range(0, pkt.size() - 1);
    gap_mode = 0;
    settle();
    check_counts("gap", 1, 11, 1, 1, 0, 0, 0);
    check("gap.type", m_type, 8'h20);
    check("gap.len", m_len, 16'h0058);
    for (int i = 0; i < 11; i++) begin
      if (b_pay + i < pay_data.size()) begin
        check("gap.data", pay_data[b_pay + i], ref_data[i]);
        check("gap.idx", pay_idx[b_pay + i], ref_idx[i]);
      end
    end

    // Reset mid-payload: nothing more comes out of the partial packet.
    build(8'h20, 8'h0E, 8'h00, 8'h00, 16'h0058, 11, 8'h55);
    send_range(0, 10);
    settle();
    check("rstmid.state_before", state_mon, 3'd2);
    snap();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check("rstmid.state", state_mon, 3'd0);
    send_range(11, pkt.size() - 1);
    settle();
    check_counts("rstmid", 0, 0, 0, 0, 0, 0, 0);
    check("rstmid.state_after", state_mon, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/t2mi_packet_parser.md
Name: t2mi_packet_parser

Overview:
- Receive-side counterpart of the T2-MI packetizer. Consumes a byte-aligned stream of T2-MI packets and parses the 6-byte header.
- Forwards payload bytes with an index, then checks the trailing CRC-32 and packet_count continuity.
- Sits after the T2-MI-over-TS extractor, which uses the TS pointer field to mark each packet's first byte with SOP_IN.

Parameters:
MAX_PAYLOAD_BYTES, 6733, largest payload accepted (3-byte BB header plus max K_bch/8); larger payloads raise LEN_ERR.

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
DATA_IN  in  8  packet byte
ENA_IN  in  1  DATA_IN valid this cycle; parser stalls when low
SOP_IN  in  1  qualified by ENA_IN; DATA_IN is the first byte of a packet
PAYLOAD_OUT  out  8  payload byte
PAYLOAD_ENA  out  1  PAYLOAD_OUT valid
PAYLOAD_IDX  out  13  index of PAYLOAD_OUT within payload, starting at 0
PKT_TYPE  out  8  header byte 0
PACKET_COUNT  out  8  header byte 1
SUPERFRAME_IDX  out  4  header byte 2 [7:4]
STREAM_ID  out  3  header byte 3 [2:0]
PAYLOAD_LEN  out  16  header bytes 4..5, in bits
HDR_VALID  out  1  one-cycle pulse when header fields are updated
PKT_DONE  out  1  one-cycle pulse at packet end
CRC_OK  out  1  CRC result, valid while PKT_DONE=1
CC_ERR  out  1  one-cycle pulse on packet_count discontinuity
LEN_ERR  out  1  one-cycle pulse when payload exceeds MAX_PAYLOAD_BYTES
ABORT  out  1  one-cycle pulse when SOP_IN arrives inside a packet
state_mon  out  3  current state

Behaviour:
- Reset: all outputs 0, state HUNT, "first packet" flag set, CRC reset to its init value.
- The design advances only on cycles with ENA_IN=1. Pulses and PAYLOAD_ENA are 0 on any cycle without a qualifying event.
- All outputs are registered, with one-cycle latency from the accepted input byte.

States:
- HUNT: bytes without SOP_IN are discarded. SOP_IN starts a new packet: CRC is initialised and absorbs this byte, header byte counter = 1, go to HEADER.
- HEADER: collect header bytes 1..5. On byte 5:
  - latch all header fields and pulse HDR_VALID;
  - compute payload bytes = ceil(PAYLOAD_LEN/8), i.e. (PAYLOAD_LEN+7)>>3, using 17-bit arithmetic truncated to 13 bits;
  - if payload bytes > MAX_PAYLOAD_BYTES: pulse LEN_ERR and go to HUNT;
  - else if payload bytes = 0: go to CRC;
  - else go to PAYLOAD.
- Continuity check, evaluated on header byte 1 and reported with HDR_VALID:
  - if not the first packet and PACKET_COUNT != previous+1 mod 256, pulse CC_ERR;
  - clear the "first packet" flag.
- PAYLOAD: each byte is echoed on PAYLOAD_OUT with PAYLOAD_ENA=1 and PAYLOAD_IDX = 0..N-1. After byte N-1, go to CRC.
- CRC: absorb 4 CRC bytes, MSB first. On the 4th byte:
  - pulse PKT_DONE;
  - CRC_OK=1 if the residual equals 32'h0 (CRC computed over header, payload and CRC bytes);
  - go to HUNT.
- The CRC absorbs every byte from SOP_IN through the last CRC byte.
- SOP_IN with ENA_IN in HEADER, PAYLOAD or CRC:
  - pulse ABORT; no PKT_DONE for the abandoned packet;
  - treat the byte as header byte 0 of a new packet (CRC re-initialised, go to HEADER);
  - PAYLOAD_ENA=0 for that byte.
- SOP_IN in HUNT is a normal start, not an abort.
- Reset mid-packet: return to HUNT immediately; a partial packet produces no pulses.
- Payload types are not interpreted; downstream blocks decode the BB, L1 and timestamp payloads using PKT_TYPE.

Decomposition:
- Shared package t2mi_pkg: header length 6, CRC length 4, packet type codes 8'h00 BB frame, 8'h10 L1-current, 8'h20 timestamp, CRC polynomial 32'h04C11DB7, CRC init 32'hFFFFFFFF, state encodings.
- Sub-module t2mi_crc32_check: byte-wide MPEG-2 CRC-32 (no reflection, no final XOR).
  - Synchronous INIT and ENA inputs; the registered CRC updates in the same cycle as the byte is accepted.
  - Shares the algorithm with the transmit-side CRC_32 but uses a synchronous active-high reset.

Test Plan:
- Timestamp packet (20 05 00 00 00 58, then 11 payload bytes, then correct CRC):
  - HDR_VALID with PKT_TYPE=8'h20, PAYLOAD_LEN=16'h0058;
  - 11 PAYLOAD_ENA pulses with IDX 0..10;
  - PKT_DONE with CRC_OK=1.
- Same packet with payload byte 3 XOR 8'h01: PKT_DONE with CRC_OK=0; payload still forwarded.
- Consecutive packets with PACKET_COUNT 8'hFF then 8'h00: no CC_ERR. Counts 8'h05 then 8'h07: CC_ERR pulse on the second header.
- PAYLOAD_LEN=16'h0009: exactly 2 payload bytes, then 4 CRC bytes.
- PAYLOAD_LEN=16'hFFF8 (8191 bytes): LEN_ERR, return to HUNT. Following bytes are ignored until SOP_IN.
- SOP_IN at payload index 4:
  - ABORT pulse, no PKT_DONE;
  - the new packet parses correctly with CRC_OK=1.
- Repeat the first case with ENA_IN toggling 1-0-0-1 randomly: identical output sequence.
- Reset asserted mid-payload: no further pulses, state_mon = HUNT.
